// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with enable, parallel load, wrap or
// saturate at the bounds, registered Gray output and wrap/block pulse.
module updown_counter_param #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned MODULUS  = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E,
    input  logic             x,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_gray,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_zero;

    // >= keeps the counter inside 0..MODULUS-1 even if a bound compare is ever reached oddly
    assign at_max  = (q_q >= MaxVal);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (load) begin
            q_d = (d > MaxVal) ? MaxVal : d;
        end else if (E) begin
            if (x) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    q_d   = SATURATE ? q_q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    ovf_d = 1'b1;
                    q_d   = SATURATE ? q_q : MaxVal;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // Gray is derived from the next count so both registers update on the same edge
    assign gray_d = q_d ^ (q_d >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q      = q_q;
    assign q_gray = gray_q;
    assign ovf    = ovf_q;
    assign tc     = E & ((x & at_max) | (~x & at_zero));

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: three configurations (2/4 wrap,
// 4/10 wrap, 4/10 saturate) checked through an expected-value queue.
module tb_updown_counter_param;

    typedef struct {
        int unsigned idx;
        logic [3:0]  q;
        logic        ovf;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst_v = '1;
    logic [2:0] e_v   = '0;
    logic [2:0] x_v   = '0;
    logic [2:0] ld_v  = '0;
    logic [1:0] d0 = '0;
    logic [3:0] d1 = '0;
    logic [3:0] d2 = '0;
    logic [1:0] q0, g0;
    logic [3:0] q1, g1, q2, g2;
    logic [2:0] tc_v, ovf_v;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b0)) u_dut0 (
        .clk(clk), .reset(rst_v[0]), .E(e_v[0]), .x(x_v[0]), .load(ld_v[0]), .d(d0),
        .q(q0), .q_gray(g0), .tc(tc_v[0]), .ovf(ovf_v[0])
    );

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_dut1 (
        .clk(clk), .reset(rst_v[1]), .E(e_v[1]), .x(x_v[1]), .load(ld_v[1]), .d(d1),
        .q(q1), .q_gray(g1), .tc(tc_v[1]), .ovf(ovf_v[1])
    );

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_dut2 (
        .clk(clk), .reset(rst_v[2]), .E(e_v[2]), .x(x_v[2]), .load(ld_v[2]), .d(d2),
        .q(q2), .q_gray(g2), .tc(tc_v[2]), .ovf(ovf_v[2])
    );

    function automatic logic [3:0] get_q(input int unsigned idx);
        case (idx)
            0:       return {2'b00, q0};
            1:       return q1;
            default: return q2;
        endcase
    endfunction

    function automatic logic [3:0] get_gray(input int unsigned idx);
        case (idx)
            0:       return {2'b00, g0};
            1:       return g1;
            default: return g2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge's inputs, check tc before the edge, queue the post-edge expectation.
    task automatic step(input int unsigned idx, input bit rst, input bit e, input bit dir,
                        input bit ld, input logic [3:0] dv, input logic [3:0] exp_q,
                        input bit exp_ovf, input bit exp_tc, input string tag);
        exp_t got;
        logic [3:0] exp_g;
        @(negedge clk);
        rst_v[idx] = rst;
        e_v[idx]   = e;
        x_v[idx]   = dir;
        ld_v[idx]  = ld;
        case (idx)
            0:       d0 = dv[1:0];
            1:       d1 = dv;
            default: d2 = dv;
        endcase
        #1;
        check({tag, "_tc"}, {3'b000, tc_v[idx]}, {3'b000, exp_tc});
        sb.push_back('{idx: idx, q: exp_q, ovf: exp_ovf, tag: tag});
        @(posedge clk);
        #1;
        got   = sb.pop_front();
        exp_g = got.q ^ (got.q >> 1);
        check({got.tag, "_q"}, get_q(got.idx), got.q);
        check({got.tag, "_gray"}, get_gray(got.idx), exp_g);
        check({got.tag, "_ovf"}, {3'b000, ovf_v[got.idx]}, {3'b000, got.ovf});
    endtask

    initial begin
        // 2-bit, modulus 4, wrap
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "t1_rst_a");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "t1_rst_b");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t1_hold_a");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t1_hold_b");
        step(0, 0, 1, 1, 0, 0, 1, 0, 0, "t2_up1");
        step(0, 0, 1, 1, 0, 0, 2, 0, 0, "t2_up2");
        step(0, 0, 1, 1, 0, 0, 3, 0, 0, "t2_up3");
        step(0, 0, 1, 1, 0, 0, 0, 1, 1, "t2_wrap");
        step(0, 0, 1, 1, 0, 0, 1, 0, 0, "t2_up5");
        step(0, 1, 1, 1, 0, 0, 0, 0, 0, "t3_rst");
        step(0, 0, 1, 0, 0, 0, 3, 1, 1, "t3_wrap_a");
        step(0, 0, 1, 0, 0, 0, 2, 0, 0, "t3_dn2");
        step(0, 0, 1, 0, 0, 0, 1, 0, 0, "t3_dn3");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, "t3_dn4");
        step(0, 0, 1, 0, 0, 0, 3, 1, 1, "t3_wrap_b");
        step(0, 0, 1, 1, 1, 2, 2, 0, 1, "t4_load");
        step(0, 0, 0, 1, 0, 0, 2, 0, 0, "t4_hold_a");
        step(0, 0, 0, 1, 0, 0, 2, 0, 0, "t4_hold_b");
        step(0, 0, 0, 1, 0, 0, 2, 0, 0, "t4_hold_c");
        step(0, 0, 1, 1, 0, 0, 3, 0, 0, "t4_up");
        step(0, 1, 1, 1, 0, 0, 0, 0, 1, "t4_rst_mid");
        step(0, 0, 1, 1, 0, 0, 1, 0, 0, "t4_resume");
        // 4-bit, modulus 10, wrap
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t5_rst");
        step(1, 0, 0, 0, 1, 15, 9, 0, 0, "t5_load_clamp");
        step(1, 0, 1, 1, 0, 0, 0, 1, 1, "t5_wrap_up");
        step(1, 0, 1, 0, 0, 0, 9, 1, 1, "t5_wrap_dn");
        step(1, 0, 1, 1, 0, 0, 0, 1, 1, "t5_dir_swap");
        step(1, 0, 1, 1, 0, 0, 1, 0, 0, "t5_up");
        step(1, 0, 1, 0, 1, 5, 5, 0, 0, "t5_load5");
        step(1, 0, 1, 0, 0, 0, 4, 0, 0, "t5_dn");
        // 4-bit, modulus 10, saturate
        step(2, 1, 0, 0, 0, 0, 0, 0, 0, "t6_rst");
        step(2, 0, 0, 0, 1, 15, 9, 0, 0, "t6_load_clamp");
        step(2, 0, 1, 1, 0, 0, 9, 1, 1, "t6_sat_hi_a");
        step(2, 0, 1, 1, 0, 0, 9, 1, 1, "t6_sat_hi_b");
        step(2, 0, 1, 1, 0, 0, 9, 1, 1, "t6_sat_hi_c");
        step(2, 0, 0, 1, 1, 0, 0, 0, 0, "t6_load0");
        step(2, 0, 1, 0, 0, 0, 0, 1, 1, "t6_sat_lo");
        step(2, 0, 1, 1, 0, 0, 1, 0, 0, "t6_up");
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
